// File: rtl/cpu_pkg.sv
// Shared definitions for the Phase-1 control sequencer.
// Opcodes, state encodings, IR field offsets and control-word bundle.
package cpu_pkg;

    localparam int OPC_WIDTH = 5;
    localparam int STATE_W   = 4;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int RA_LSB    = 23;
    localparam int RB_LSB    = 19;
    localparam int RC_LSB    = 15;
    localparam int REG_IDX_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_HALTED = 4'd8
    } state_e;

    typedef struct packed {
        logic alu3;
        logic muldiv;
        logic unary;
        logic nop;
        logic halt;
        logic illegal;
    } op_class_t;

    typedef struct packed {
        logic                 pc_out;
        logic                 pc_in;
        logic                 inc_pc;
        logic                 mar_in;
        logic                 mdr_in;
        logic                 read;
        logic                 mdr_out;
        logic                 ir_in;
        logic                 y_in;
        logic                 z_in;
        logic                 zlow_out;
        logic                 zhigh_out;
        logic                 lo_in;
        logic                 hi_in;
        logic                 gra;
        logic                 grb;
        logic                 grc;
        logic                 r_in;
        logic                 r_out;
        logic [OPC_WIDTH-1:0] opcode;
        logic                 illegal_op;
    } ctrl_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Classifies the IR opcode into the execute-sequence family.
// Exactly one class bit is set for any opcode value.
module opcode_class_decode
    import cpu_pkg::*;
(
    input  logic [OPC_WIDTH-1:0] ir_opcode,
    output op_class_t            op_class
);

    always_comb begin
        op_class = '0;
        unique case (1'b1)
            (ir_opcode >= OP_ADD && ir_opcode <= OP_SHL):
                op_class.alu3 = 1'b1;
            (ir_opcode == OP_MUL || ir_opcode == OP_DIV):
                op_class.muldiv = 1'b1;
            (ir_opcode == OP_NEG || ir_opcode == OP_NOT):
                op_class.unary = 1'b1;
            (ir_opcode == OP_NOP):
                op_class.nop = 1'b1;
            (ir_opcode == OP_HALT):
                op_class.halt = 1'b1;
            default:
                op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/div_mul_alu_control_unit.sv
// Moore sequencer for fetch (T0-T2) and execute (T3-T6) of the Phase-1 datapath.
// Control outputs decode from the current state and the latched IR opcode.
module div_mul_alu_control_unit
    import cpu_pkg::*;
#(
    parameter int OPC_W = OPC_WIDTH,
    parameter int ST_W  = STATE_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [OPC_W-1:0] ir_opcode,
    output logic             PCout,
    output logic             PCin,
    output logic             incPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             read,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             ZLowOut,
    output logic             ZHighOut,
    output logic             LOin,
    output logic             HIin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic [OPC_W-1:0] opcode,
    output logic             run_out,
    output logic             illegal_op,
    output logic [ST_W-1:0]  state_dbg
);

    state_e    state_q;
    state_e    state_d;
    state_e    end_st;
    op_class_t cls;
    ctrl_t     c;

    opcode_class_decode u_dec (
        .ir_opcode (ir_opcode),
        .op_class  (cls)
    );

    assign end_st = run ? ST_T0 : ST_IDLE;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (run) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (cls.halt)
                    state_d = ST_HALTED;
                else if (cls.alu3 || cls.muldiv || cls.unary)
                    state_d = ST_T4;
                else
                    state_d = end_st;
            end
            ST_T4: begin
                if (cls.alu3 || cls.muldiv)
                    state_d = ST_T5;
                else
                    state_d = end_st;
            end
            ST_T5:     state_d = cls.muldiv ? ST_T6 : end_st;
            ST_T6:     state_d = end_st;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // IDLE, HALTED and unreached encodings leave every control low.
    always_comb begin
        c = '0;
        unique case (state_q)
            ST_T0: begin
                c.pc_out = 1'b1;
                c.mar_in = 1'b1;
                c.inc_pc = 1'b1;
                c.z_in   = 1'b1;
            end
            ST_T1: begin
                c.zlow_out = 1'b1;
                c.pc_in    = 1'b1;
                c.read     = 1'b1;
                c.mdr_in   = 1'b1;
            end
            ST_T2: begin
                c.mdr_out = 1'b1;
                c.ir_in   = 1'b1;
            end
            ST_T3: begin
                unique case (1'b1)
                    cls.alu3: begin
                        c.grb   = 1'b1;
                        c.r_out = 1'b1;
                        c.y_in  = 1'b1;
                    end
                    cls.muldiv: begin
                        c.gra   = 1'b1;
                        c.r_out = 1'b1;
                        c.y_in  = 1'b1;
                    end
                    cls.unary: begin
                        c.grb    = 1'b1;
                        c.r_out  = 1'b1;
                        c.z_in   = 1'b1;
                        c.opcode = ir_opcode;
                    end
                    cls.illegal: c.illegal_op = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                unique case (1'b1)
                    cls.alu3: begin
                        c.grc    = 1'b1;
                        c.r_out  = 1'b1;
                        c.z_in   = 1'b1;
                        c.opcode = ir_opcode;
                    end
                    cls.muldiv: begin
                        c.grb    = 1'b1;
                        c.r_out  = 1'b1;
                        c.z_in   = 1'b1;
                        c.opcode = ir_opcode;
                    end
                    cls.unary: begin
                        c.zlow_out = 1'b1;
                        c.gra      = 1'b1;
                        c.r_in     = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                unique case (1'b1)
                    cls.alu3: begin
                        c.zlow_out = 1'b1;
                        c.gra      = 1'b1;
                        c.r_in     = 1'b1;
                    end
                    cls.muldiv: begin
                        c.zlow_out = 1'b1;
                        c.lo_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                if (cls.muldiv) begin
                    c.zhigh_out = 1'b1;
                    c.hi_in     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign PCout      = c.pc_out;
    assign PCin       = c.pc_in;
    assign incPC      = c.inc_pc;
    assign MARin      = c.mar_in;
    assign MDRin      = c.mdr_in;
    assign read       = c.read;
    assign MDRout     = c.mdr_out;
    assign IRin       = c.ir_in;
    assign Yin        = c.y_in;
    assign Zin        = c.z_in;
    assign ZLowOut    = c.zlow_out;
    assign ZHighOut   = c.zhigh_out;
    assign LOin       = c.lo_in;
    assign HIin       = c.hi_in;
    assign Gra        = c.gra;
    assign Grb        = c.grb;
    assign Grc        = c.grc;
    assign Rin        = c.r_in;
    assign Rout       = c.r_out;
    assign opcode     = c.opcode;
    assign illegal_op = c.illegal_op;
    assign run_out    = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign state_dbg  = ST_W'(state_q);

endmodule

// File: tb/tb_div_mul_alu_control_unit.sv
// Bench: sequencer driving a behavioural Phase-1 datapath, checked
// against an instruction-level model of register, LO/HI and timing effects.
module tb_div_mul_alu_control_unit;

    localparam logic [4:0] T_MUL  = 5'b01110;
    localparam logic [4:0] T_DIV  = 5'b01111;
    localparam logic [4:0] T_NEG  = 5'b10000;
    localparam logic [4:0] T_NOT  = 5'b10001;
    localparam logic [4:0] T_NOP  = 5'b11010;
    localparam logic [4:0] T_HALT = 5'b11011;

    localparam logic [18:0] C_T0 =
        (19'd1 << 18) | (19'd1 << 16) | (19'd1 << 15) | (19'd1 << 9);

    logic clock;
    logic clear;
    logic run;
    logic [4:0] ir_opcode;
    logic PCout, PCin, incPC, MARin, MDRin, read, MDRout, IRin;
    logic Yin, Zin, ZLowOut, ZHighOut, LOin, HIin;
    logic Gra, Grb, Grc, Rin, Rout;
    logic [4:0] opcode;
    logic run_out, illegal_op;
    logic [3:0] state_dbg;

    int checks = 0;
    int fails = 0;

    div_mul_alu_control_unit dut (
        .clock(clock), .clear(clear), .run(run), .ir_opcode(ir_opcode),
        .PCout(PCout), .PCin(PCin), .incPC(incPC), .MARin(MARin),
        .MDRin(MDRin), .read(read), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
        .LOin(LOin), .HIin(HIin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .opcode(opcode), .run_out(run_out),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [18:0] ctrl;
    assign ctrl = {PCout, PCin, incPC, MARin, MDRin, read, MDRout, IRin,
                   Yin, Zin, ZLowOut, ZHighOut, LOin, HIin,
                   Gra, Grb, Grc, Rin, Rout};

    function automatic logic [63:0] alu(input logic [4:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
        logic [63:0] t;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            5'd3:  return {32'd0, a + b};
            5'd4:  return {32'd0, a - b};
            5'd5:  return {32'd0, a & b};
            5'd6:  return {32'd0, a | b};
            5'd7: begin
                t = {a, a} >> b[4:0];
                return {32'd0, t[31:0]};
            end
            5'd8: begin
                t = {a, a} << b[4:0];
                return {32'd0, t[63:32]};
            end
            5'd9:  return {32'd0, a >> b[4:0]};
            5'd10: return {32'd0, 32'($signed(a) >>> b[4:0])};
            5'd11: return {32'd0, a << b[4:0]};
            5'd14: return sa * sb;
            5'd15: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            5'd16: return {32'd0, -b};
            5'd17: return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    // Behavioural datapath: bus, register file, PC/MAR/MDR/IR/Y/Z/LO/HI.
    logic [31:0] mem [64];
    logic [31:0] R [16];
    logic [31:0] R_init [16];
    logic [31:0] PC, MAR, MDR, IR, Y, LO, HI, LO_init, HI_init;
    logic [63:0] Z;
    logic [31:0] bus;
    logic [3:0]  sel;
    logic        dp_load = 1'b0;

    assign ir_opcode = IR[31:27];
    assign sel = Gra ? IR[26:23] : Grb ? IR[22:19] : Grc ? IR[18:15] : 4'd0;
    assign bus = PCout    ? PC :
                 MDRout   ? MDR :
                 ZLowOut  ? Z[31:0] :
                 ZHighOut ? Z[63:32] :
                 Rout     ? R[sel] : 32'd0;

    always @(posedge clock) begin
        if (dp_load) begin
            for (int i = 0; i < 16; i++) R[i] <= R_init[i];
            PC <= 32'd0;
            IR <= 32'd0;
            LO <= LO_init;
            HI <= HI_init;
            Z  <= 64'd0;
        end else begin
            if (PCin)  PC  <= bus;
            if (MARin) MAR <= bus;
            if (MDRin) MDR <= read ? mem[MAR[5:0]] : bus;
            if (IRin)  IR  <= bus;
            if (Yin)   Y   <= bus;
            if (Zin)   Z   <= incPC ? {32'd0, bus + 32'd1} : alu(opcode, Y, bus);
            if (LOin)  LO  <= bus;
            if (HIin)  HI  <= bus;
            if (Rin)   R[sel] <= bus;
        end
    end

    logic [31:0] prog [$];

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'd0};
    endfunction

    function automatic int lat_of(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return 6;
        if (op == T_MUL || op == T_DIV) return 7;
        if (op == T_NEG || op == T_NOT) return 5;
        return 4;
    endfunction

    task automatic setup();
        clear = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = enc(T_HALT, 0, 0, 0);
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
        dp_load = 1'b1;
        @(posedge clock);
        #1 dp_load = 1'b0;
    endtask

    task automatic start();
        @(negedge clock);
        clear = 1'b0;
        run = 1'b1;
    endtask

    task automatic wait_state(input logic [3:0] s, input int max, output int n);
        n = 0;
        do begin
            @(posedge clock);
            #1 n++;
        end while (state_dbg !== s && n < max);
    endtask

    task automatic test_reset();
        clear = 1'b1;
        run = 1'b1;
        @(negedge clock);
        checks++;
        if (ctrl !== 19'd0 || opcode !== 5'd0 || illegal_op !== 1'b0 || run_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: ctrl=%h opc=%h ill=%b run_out=%b, want all 0",
                     ctrl, opcode, illegal_op, run_out);
        end
        checks++;
        if (state_dbg !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d want 0", state_dbg);
        end
        run = 1'b0;
        clear = 1'b0;
        repeat (3) @(posedge clock);
        #1 checks++;
        if (state_dbg !== 4'd0) begin
            fails++;
            $display("FAIL idle_hold: got %0d want 0", state_dbg);
        end
    endtask

    task automatic test_add();
        int n;
        for (int i = 0; i < 16; i++) R_init[i] = 32'd0;
        R_init[2] = 32'd30;
        R_init[3] = 32'd25;
        LO_init = 0;
        HI_init = 0;
        prog = {};
        prog.push_back(enc(5'd3, 1, 2, 3));
        prog.push_back(enc(T_NOP, 0, 0, 0));
        setup();
        start();
        @(posedge clock);
        #1 checks++;
        if (state_dbg !== 4'd1 || ctrl !== C_T0 || opcode !== 5'd0) begin
            fails++;
            $display("FAIL t0_outputs: state=%0d ctrl=%h opc=%h want 1 %h 0",
                     state_dbg, ctrl, opcode, C_T0);
        end
        repeat (2) @(posedge clock);
        #1 checks++;
        if (PC !== 32'd1 || state_dbg !== 4'd3) begin
            fails++;
            $display("FAIL fetch_pc: pc=%0d state=%0d want 1 3", PC, state_dbg);
        end
        wait_state(4'd1, 20, n);
        checks++;
        if (n + 2 != 6 || state_dbg !== 4'd1) begin
            fails++;
            $display("FAIL add_latency: got %0d state=%0d want 6 1", n + 2, state_dbg);
        end
        checks++;
        if (R[1] !== 32'd55) begin
            fails++;
            $display("FAIL add_result: R1=%0d want 55", R[1]);
        end
    endtask

    task automatic test_div();
        int n;
        int opc_cnt;
        int opc_bad;
        for (int i = 0; i < 16; i++) R_init[i] = 32'd0;
        R_init[2] = 32'd30;
        R_init[6] = 32'd25;
        LO_init = 32'hDEAD;
        HI_init = 32'hBEEF;
        prog = {};
        prog.push_back(enc(T_DIV, 2, 6, 0));
        prog.push_back(enc(T_NOP, 0, 0, 0));
        setup();
        start();
        wait_state(4'd1, 5, n);
        opc_cnt = 0;
        opc_bad = 0;
        n = 0;
        do begin
            @(posedge clock);
            #1 n++;
            if (opcode !== 5'd0) begin
                opc_cnt++;
                if (opcode !== T_DIV || state_dbg !== 4'd5) opc_bad++;
            end
        end while (state_dbg !== 4'd1 && n < 30);
        checks++;
        if (n != 7) begin
            fails++;
            $display("FAIL div_latency: got %0d want 7", n);
        end
        checks++;
        if (opc_cnt != 1 || opc_bad != 0) begin
            fails++;
            $display("FAIL div_opcode_window: cycles=%0d bad=%0d want 1 0", opc_cnt, opc_bad);
        end
        checks++;
        if (LO !== 32'd1 || HI !== 32'd5) begin
            fails++;
            $display("FAIL div_result: LO=%0d HI=%0d want 1 5", LO, HI);
        end
    endtask

    task automatic test_mul_run_drop();
        int n;
        for (int i = 0; i < 16; i++) R_init[i] = 32'd0;
        R_init[5] = -32'sd3;
        R_init[7] = 32'd7;
        LO_init = 0;
        HI_init = 0;
        prog = {};
        prog.push_back(enc(T_MUL, 5, 7, 0));
        prog.push_back(enc(T_MUL, 5, 7, 0));
        setup();
        start();
        wait_state(4'd1, 5, n);
        repeat (2) @(posedge clock);
        #1 run = 1'b0;
        wait_state(4'd0, 20, n);
        checks++;
        if (n + 2 != 7 || state_dbg !== 4'd0) begin
            fails++;
            $display("FAIL mul_to_idle: got %0d state=%0d want 7 0", n + 2, state_dbg);
        end
        checks++;
        if (LO !== 32'hFFFF_FFEB || HI !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL mul_result: LO=%h HI=%h want ffffffeb ffffffff", LO, HI);
        end
        repeat (5) @(posedge clock);
        #1 checks++;
        if (state_dbg !== 4'd0 || PC !== 32'd1 || run_out !== 1'b0) begin
            fails++;
            $display("FAIL run_drop_idle: state=%0d pc=%0d run_out=%b want 0 1 0",
                     state_dbg, PC, run_out);
        end
    endtask

    task automatic test_clear_abort();
        int n;
        for (int i = 0; i < 16; i++) R_init[i] = 32'd0;
        R_init[2] = 32'd30;
        R_init[6] = 32'd25;
        LO_init = 32'h1111;
        HI_init = 32'h2222;
        prog = {};
        prog.push_back(enc(T_DIV, 2, 6, 0));
        setup();
        start();
        wait_state(4'd5, 20, n);
        checks++;
        if (state_dbg !== 4'd5 || opcode !== T_DIV) begin
            fails++;
            $display("FAIL clear_reach_t4: state=%0d opc=%h want 5 0f", state_dbg, opcode);
        end
        #2 clear = 1'b1;
        #1 checks++;
        if (ctrl !== 19'd0 || opcode !== 5'd0 || state_dbg !== 4'd0) begin
            fails++;
            $display("FAIL clear_abort: ctrl=%h opc=%h state=%0d want 0 0 0",
                     ctrl, opcode, state_dbg);
        end
        repeat (2) @(posedge clock);
        #1 checks++;
        if (LO !== 32'h1111 || HI !== 32'h2222) begin
            fails++;
            $display("FAIL clear_lohi: LO=%h HI=%h want 1111 2222", LO, HI);
        end
    endtask

    task automatic test_illegal_halt();
        int ill;
        int ill_bad;
        int t0s;
        int t0at [4];
        int hold_bad;
        for (int i = 0; i < 16; i++) R_init[i] = 32'h100 + i;
        LO_init = 0;
        HI_init = 0;
        prog = {};
        prog.push_back(enc(5'b11111, 1, 2, 3));
        prog.push_back(enc(T_HALT, 0, 0, 0));
        setup();
        start();
        ill = 0;
        ill_bad = 0;
        t0s = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (illegal_op === 1'b1) begin
                ill++;
                if (state_dbg !== 4'd4 || ctrl !== 19'd0 || opcode !== 5'd0) ill_bad++;
            end
            if (state_dbg === 4'd1 && t0s < 4) begin
                t0at[t0s] = c;
                t0s++;
            end
            if (state_dbg === 4'd8) break;
        end
        checks++;
        if (ill != 1 || ill_bad != 0) begin
            fails++;
            $display("FAIL illegal_pulse: count=%0d bad=%0d want 1 0", ill, ill_bad);
        end
        checks++;
        if (t0s != 2 || t0at[1] - t0at[0] != 4) begin
            fails++;
            $display("FAIL illegal_latency: t0s=%0d gap=%0d want 2 4", t0s, t0at[1] - t0at[0]);
        end
        checks++;
        if (R[1] !== 32'h101 || R[2] !== 32'h102 || R[3] !== 32'h103) begin
            fails++;
            $display("FAIL illegal_nowrite: R1=%h R2=%h R3=%h want 101 102 103", R[1], R[2], R[3]);
        end
        hold_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1 checks++;
            if (state_dbg !== 4'd8 || ctrl !== 19'd0 || opcode !== 5'd0 ||
                run_out !== 1'b0 || illegal_op !== 1'b0) begin
                fails++;
                hold_bad++;
                if (hold_bad < 4)
                    $display("FAIL halt_hold: cycle %0d state=%0d ctrl=%h run_out=%b want 8 0 0",
                             c, state_dbg, ctrl, run_out);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] mR [16];
        logic [31:0] mLO;
        logic [31:0] mHI;
        logic [63:0] t;
        logic [4:0]  op;
        logic [3:0]  ra, rb, rc;
        int n;
        int k;
        int inv_bad;
        int len;
        bit done;
        for (int p = 0; p < 5; p++) begin
            prog = {};
            for (int i = 0; i < 14; i++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 9: op = 5'(3 + $urandom_range(0, 8));
                    4, 5: op = $urandom_range(0, 1) ? T_MUL : T_DIV;
                    6: op = $urandom_range(0, 1) ? T_NEG : T_NOT;
                    7: op = T_NOP;
                    default: begin
                        do op = 5'($urandom_range(0, 31));
                        while ((op >= 5'd3 && op <= 5'd11) || op == T_MUL || op == T_DIV ||
                               op == T_NEG || op == T_NOT || op == T_NOP || op == T_HALT);
                    end
                endcase
                prog.push_back(enc(op, 4'($urandom), 4'($urandom), 4'($urandom)));
            end
            prog.push_back(enc(T_HALT, 0, 0, 0));
            len = prog.size();
            for (int i = 0; i < 16; i++) begin
                R_init[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                mR[i] = R_init[i];
            end
            LO_init = $urandom;
            HI_init = $urandom;
            mLO = LO_init;
            mHI = HI_init;
            done = 1'b0;
            for (int i = 0; i < len && !done; i++) begin
                op = prog[i][31:27];
                ra = prog[i][26:23];
                rb = prog[i][22:19];
                rc = prog[i][18:15];
                if (op >= 5'd3 && op <= 5'd11) begin
                    t = alu(op, mR[rb], mR[rc]);
                    mR[ra] = t[31:0];
                end else if (op == T_MUL || op == T_DIV) begin
                    t = alu(op, mR[ra], mR[rb]);
                    mLO = t[31:0];
                    mHI = t[63:32];
                end else if (op == T_NEG || op == T_NOT) begin
                    t = alu(op, 32'd0, mR[rb]);
                    mR[ra] = t[31:0];
                end else if (op == T_HALT) begin
                    done = 1'b1;
                end
            end
            setup();
            start();
            n = 0;
            k = 0;
            inv_bad = 0;
            for (int c = 0; c < 200; c++) begin
                @(posedge clock);
                #1 n++;
                checks++;
                if ($countones({PCout, MDRout, ZLowOut, ZHighOut, Rout}) > 1 ||
                    $countones({Gra, Grb, Grc}) > 1 ||
                    run_out !== (state_dbg != 4'd0 && state_dbg != 4'd8)) begin
                    fails++;
                    inv_bad++;
                    if (inv_bad < 4)
                        $display("FAIL invariants: state=%0d ctrl=%h run_out=%b", state_dbg, ctrl, run_out);
                end
                if (state_dbg === 4'd1) begin
                    if (k > 0) begin
                        checks++;
                        if (n != lat_of(prog[k-1][31:27])) begin
                            fails++;
                            $display("FAIL latency: instr %0d op=%b got %0d want %0d",
                                     k - 1, prog[k-1][31:27], n, lat_of(prog[k-1][31:27]));
                        end
                    end
                    k++;
                    n = 0;
                end
                if (state_dbg === 4'd8) break;
            end
            checks++;
            if (state_dbg !== 4'd8 || k != len || PC !== 32'(len)) begin
                fails++;
                $display("FAIL rand_halt: prog %0d state=%0d fetched=%0d pc=%0d want 8 %0d %0d",
                         p, state_dbg, k, PC, len, len);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (R[i] !== mR[i]) begin
                    fails++;
                    $display("FAIL rand_reg: prog %0d R%0d got %h want %h", p, i, R[i], mR[i]);
                end
            end
            checks++;
            if (LO !== mLO || HI !== mHI) begin
                fails++;
                $display("FAIL rand_lohi: prog %0d LO=%h HI=%h want %h %h", p, LO, HI, mLO, mHI);
            end
        end
    endtask

    initial begin
        clear = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 16; i++) R_init[i] = 32'd0;
        LO_init = 0;
        HI_init = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        test_reset();
        test_add();
        test_div();
        test_mul_run_drop();
        test_clear_abort();
        test_illegal_halt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
